burst_shifter: RTL and testbench

- Parametrised, loadable shift register with a counter, the next generation of the team's basic shift-register block.
- A parallel-loaded word is shifted a programmable number of positions, one position per clock, under a start/busy/done handshake.
- Four shift modes and a serial fill input; tracks the last bit shifted out and the shifts performed since the last load.
- Used by serialisers and bit-field extraction logic in the j1a peripheral path.

---
 rtl/burst_shifter_pkg.sv | 22 ++
 rtl/shift_step.sv | 49 ++++
 rtl/burst_shifter.sv | 142 ++++++++++++++
 tb/tb_burst_shifter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_shifter_pkg
// Brief    : Shared mode constants and FSM state encoding for burst_shifter.
// Revision : 1.0 - initial release
// ============================================================================
package burst_shifter_pkg;

    // Shift-mode encodings carried on the mode input
    localparam logic [1:0] MODE_SHL = 2'b00;  // logical left, sin fills LSB
    localparam logic [1:0] MODE_SHR = 2'b01;  // logical right, sin fills MSB
    localparam logic [1:0] MODE_ASR = 2'b10;  // arithmetic right, MSB replicated
    localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left

    // Burst controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : burst_shifter_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Brief    : Combinational single-position shift of a WIDTH-bit word in one
//            of four modes; returns the shifted word and the bit pushed out.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
    import burst_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    // Select the shifted word and the departing bit for the requested mode
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_value = {value[WIDTH-2:0], sin};
                out_bit    = value[WIDTH-1];
            end
            MODE_SHR: begin
                next_value = {sin, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/burst_shifter.sv
`default_nettype none
// ============================================================================
// Module   : burst_shifter
// Brief    : Loadable shift register that performs a programmable burst of
//            single-position shifts (one per clock) under a start/busy/done
//            handshake, tracking the last bit out and shifts since load.
// Revision : 1.0 - initial release
// ============================================================================
module burst_shifter
    import burst_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done
);

    // A burst never exceeds WIDTH shifts; AMT_W is sized so WIDTH fits.
    localparam logic [AMT_W-1:0] c_amt_max = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] c_amt_one = AMT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   w_dout_nxt;
    logic               r_sout;
    logic               w_sout_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [AMT_W-1:0]   r_rem;
    logic [AMT_W-1:0]   w_rem_nxt;
    logic [1:0]         r_mode;
    logic [1:0]         w_mode_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   w_step_value;
    logic               w_step_out;

    // The mode is latched at start so mid-burst changes on the pin are
    // ignored; sin is deliberately taken live on every shift edge.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .value      (r_dout),
        .mode       (r_mode),
        .sin        (sin),
        .next_value (w_step_value),
        .out_bit    (w_step_out)
    );

    // State register; reset aborts any burst in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; load wins over start in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_sout_nxt  = r_sout;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_dout_nxt = din;
                    w_cnt_nxt  = '0;
                    w_sout_nxt = 1'b0;
                end else if (start) begin
                    w_mode_nxt  = mode;
                    w_rem_nxt   = (amt > c_amt_max) ? c_amt_max : amt;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_rem != '0) begin
                    w_dout_nxt = w_step_value;
                    w_sout_nxt = w_step_out;
                    w_cnt_nxt  = r_cnt + c_cnt_one;
                    w_rem_nxt  = r_rem - c_amt_one;
                end
                // A zero-length burst still spends one cycle in SHIFT so
                // the done pulse always arrives at least one edge after start.
                if (r_rem <= c_amt_one) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: word, last-out bit, counters, latched mode, done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_mode <= MODE_SHL;
            r_done <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_sout <= w_sout_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rem  <= w_rem_nxt;
            r_mode <= w_mode_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign dout = r_dout;
    assign sout = r_sout;
    assign cnt  = r_cnt;
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;

endmodule : burst_shifter
`default_nettype wire

// File: tb/tb_burst_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_shifter
// Brief    : Self-checking bench for burst_shifter: a behavioural model is
//            compared every cycle against two instances (CNT_W=8 and 4),
//            with directed scenarios and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_shifter;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       load  = 1'b0;
    logic       start = 1'b0;
    logic       sin   = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [3:0] amt   = 4'h0;
    logic [1:0] mode  = 2'b00;

    logic [7:0] dout_a, dout_b;
    logic       sout_a, sout_b;
    logic [7:0] cnt_a;
    logic [3:0] cnt_b;
    logic       busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    burst_shifter #(.WIDTH(8), .AMT_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
        .amt(amt), .mode(mode), .sin(sin), .dout(dout_a), .sout(sout_a),
        .cnt(cnt_a), .busy(busy_a), .done(done_a)
    );

    burst_shifter #(.WIDTH(8), .AMT_W(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
        .amt(amt), .mode(mode), .sin(sin), .dout(dout_b), .sout(sout_b),
        .cnt(cnt_b), .busy(busy_b), .done(done_b)
    );

    // ---------------- behavioural model ----------------
    int m_dout = 0, m_sout = 0, m_cnt = 0, m_left = 0, m_mode = 0;
    bit m_busy = 0, m_done = 0;

    function automatic int shifted(input int v, input int md, input int s);
        case (md)
            0:       return (v * 2 + s) % 256;
            1:       return v / 2 + s * 128;
            2:       return v / 2 + ((v >= 128) ? 128 : 0);
            default: return (v * 2) % 256 + v / 128;
        endcase
    endfunction

    function automatic int bit_out(input int v, input int md);
        if (md == 0 || md == 3) return v / 128;
        return v % 2;
    endfunction

    // Model update on each clock edge, cleared asynchronously by reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dout = 0; m_sout = 0; m_cnt = 0; m_left = 0;
            m_busy = 0; m_done = 0; m_mode = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (load) begin
                    m_dout = int'(din); m_cnt = 0; m_sout = 0;
                end else if (start) begin
                    m_mode = int'(mode);
                    m_left = (int'(amt) > 8) ? 8 : int'(amt);
                    m_busy = 1;
                end
            end else begin
                if (m_left > 0) begin
                    m_sout = bit_out(m_dout, m_mode);
                    m_dout = shifted(m_dout, m_mode, int'(sin));
                    m_cnt  = m_cnt + 1;
                    m_left = m_left - 1;
                end
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        check("dout",   32'(dout_a), 32'(m_dout));
        check("sout",   32'(sout_a), 32'(m_sout));
        check("cnt",    32'(cnt_a),  32'(m_cnt % 256));
        check("busy",   32'(busy_a), 32'(m_busy));
        check("done",   32'(done_a), 32'(m_done));
        check("dout4",  32'(dout_b), 32'(m_dout));
        check("sout4",  32'(sout_b), 32'(m_sout));
        check("cnt4",   32'(cnt_b),  32'(m_cnt % 16));
        check("busy4",  32'(busy_b), 32'(m_busy));
        check("done4",  32'(done_b), 32'(m_done));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d);
        load = 1'b1; din = d;
        step();
        load = 1'b0; din = 8'($urandom);
    endtask

    task automatic do_start(input logic [3:0] a, input logic [1:0] md);
        start = 1'b1; amt = a; mode = md;
        step();
        start = 1'b0; amt = 4'($urandom); mode = 2'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy_a && k < limit) begin
            step();
            k++;
        end
        check("wait_idle_timeout", 32'(busy_a), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1 reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("lit_rst_dout", 32'(dout_a), 32'h0);
        check("lit_rst_busy", 32'(busy_a), 32'h0);
        check("lit_rst_done", 32'(done_a), 32'h0);

        // Parallel load
        do_load(8'hA5);
        check("lit_load_dout", 32'(dout_a), 32'hA5);
        check("lit_load_cnt",  32'(cnt_a),  32'h0);
        check("lit_load_sout", 32'(sout_a), 32'h0);

        // Logical left, sin=1
        do_load(8'h81);
        sin = 1'b1;
        do_start(4'd3, 2'b00);
        check("lit_shl_busy0", 32'(busy_a), 32'h1);
        check("lit_shl_dout0", 32'(dout_a), 32'h81);
        step();
        check("lit_shl_d1", 32'(dout_a), 32'h03);
        check("lit_shl_s1", 32'(sout_a), 32'h1);
        step();
        check("lit_shl_d2", 32'(dout_a), 32'h07);
        check("lit_shl_s2", 32'(sout_a), 32'h0);
        step();
        check("lit_shl_d3",   32'(dout_a), 32'h0F);
        check("lit_shl_cnt",  32'(cnt_a),  32'h3);
        check("lit_shl_done", 32'(done_a), 32'h1);
        check("lit_shl_busy", 32'(busy_a), 32'h0);
        step();
        check("lit_shl_done_off", 32'(done_a), 32'h0);

        // Arithmetic right then logical right started in the done cycle
        do_load(8'h90);
        do_start(4'd2, 2'b10);
        step();
        check("lit_asr_d1", 32'(dout_a), 32'hC8);
        step();
        check("lit_asr_d2",  32'(dout_a), 32'hE4);
        check("lit_asr_s",   32'(sout_a), 32'h0);
        check("lit_asr_cnt", 32'(cnt_a),  32'h2);
        sin = 1'b0;
        do_start(4'd1, 2'b01);
        step();
        check("lit_shr_d",   32'(dout_a), 32'h72);
        check("lit_shr_cnt", 32'(cnt_a),  32'h3);

        // Rotate with saturating amount
        do_load(8'h81);
        do_start(4'd12, 2'b11);
        wait_idle(20);
        check("lit_rol_d",   32'(dout_a), 32'h81);
        check("lit_rol_s",   32'(sout_a), 32'h1);
        check("lit_rol_cnt", 32'(cnt_a),  32'h8);

        // Zero-length burst
        do_start(4'd0, 2'b00);
        check("lit_amt0_busy", 32'(busy_a), 32'h1);
        step();
        check("lit_amt0_done", 32'(done_a), 32'h1);
        check("lit_amt0_d",    32'(dout_a), 32'h81);
        check("lit_amt0_cnt",  32'(cnt_a),  32'h8);

        // load/start pulsed mid-burst are ignored
        sin = 1'($urandom);
        do_start(4'd4, 2'b01);
        step();
        load = 1'b1; start = 1'b1; din = 8'hFF;
        step();
        load = 1'b0; start = 1'b0;
        wait_idle(10);
        check("lit_ign_cnt",  32'(cnt_a),  32'd12);
        check("lit_ign_done", 32'(done_a), 32'h1);

        // Simultaneous load and start in IDLE: load only
        load = 1'b1; start = 1'b1; din = 8'h3C; amt = 4'd3;
        step();
        load = 1'b0; start = 1'b0;
        check("lit_ls_busy", 32'(busy_a), 32'h0);
        check("lit_ls_dout", 32'(dout_a), 32'h3C);

        // Counter wrap on the CNT_W=4 instance
        do_load(8'h00);
        do_start(4'd8, 2'b11); wait_idle(20);
        do_start(4'd8, 2'b11); wait_idle(20);
        do_start(4'd2, 2'b11); wait_idle(20);
        check("lit_wrap_cnt4", 32'(cnt_b), 32'h2);
        check("lit_wrap_cnt8", 32'(cnt_a), 32'd18);

        // Asynchronous reset mid-burst
        do_load(8'h55);
        do_start(4'd5, 2'b00);
        step(); step();
        #1 reset = 1'b1;
        #1;
        check("lit_arst_dout", 32'(dout_a), 32'h0);
        check("lit_arst_cnt",  32'(cnt_a),  32'h0);
        check("lit_arst_busy", 32'(busy_a), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("lit_arst_nodone", 32'(done_a), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(0, 5) == 0);
            start = ($urandom_range(0, 2) == 0);
            din   = 8'($urandom);
            amt   = 4'($urandom);
            mode  = 2'($urandom);
            sin   = 1'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0; start = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_burst_shifter
`default_nettype wire
